// File: rtl/frogger_pkg.sv
// frogger_pkg: sound codes, note/duration tables and half-period helper shared by the sound player.
package frogger_pkg;
  typedef enum logic [1:0] {UI_PRESS = 2'd0, NEXTLEVEL = 2'd1, CRASH = 2'd2, CELEBRATION = 2'd3} sound_t;
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  // Lowest audible note in any table; sizes the half-period counter.
  localparam int unsigned MIN_HZ = 125;
  localparam int unsigned NOTE_HZ [4][4] = '{
    '{1000, 0, 0, 0},
    '{500, 1000, 0, 0},
    '{250, 0, 125, 0},
    '{500, 625, 1000, 1250}
  };
  localparam logic [7:0] DUR_TICKS [4][4] = '{
    '{8'd30, 8'd0, 8'd0, 8'd0},
    '{8'd60, 8'd60, 8'd0, 8'd0},
    '{8'd100, 8'd50, 8'd150, 8'd0},
    '{8'd40, 8'd40, 8'd40, 8'd120}
  };
  localparam logic [2:0] STEP_CNT [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned f);
    return f == 0 ? 0 : clk_hz / (2 * f);
  endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave toggling every half_period cycles; half_period=0 is silence.
module tone_gen #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic [W-1:0] half_period,
  output logic         sq
);
  logic [W-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, wrap, hold;
  assign wrap = cnt_q == half_period - 1'b1;
  assign hold = restart || half_period == '0;
  always_comb begin
    cnt_d = (hold || wrap) ? '0 : cnt_q + 1'b1;
    sq_d = hold ? 1'b0 : sq_q ^ wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q <= sq_d;
    end
  end
  assign sq = sq_q;
endmodule

// File: rtl/sound_player.sv
// sound_player: plays fixed note sequences as a square wave, with restart on a new request.
module sound_player #(
  parameter int CLK_HZ = 25_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] soundselector,
  input  logic       playsound,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic       done
);
  import frogger_pkg::*;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam int HPW = $clog2(half_period(CLK_HZ, MIN_HZ) + 1);
  state_t state_q, state_d;
  sound_t sel_q, sel_d;
  logic [1:0] step_q, step_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] dur_q, dur_d;
  logic play_q, trig, tick_end, step_end, last_end, restart, clear, sq;
  logic [HPW-1:0] hp_tab [4][4];
  for (genvar s = 0; s < 4; s++) begin : g_s
    for (genvar t = 0; t < 4; t++) begin : g_t
      assign hp_tab[s][t] = HPW'(half_period(CLK_HZ, NOTE_HZ[s][t]));
    end
  end
  assign trig = playsound & ~play_q;
  assign tick_end = pre_q == PW'(TICK_DIV - 1);
  assign step_end = state_q == PLAY && tick_end && dur_q == DUR_TICKS[sel_q][step_q] - 8'd1;
  assign last_end = step_end && {1'b0, step_q} + 3'd1 == STEP_CNT[sel_q];
  assign restart = trig | step_end;
  assign clear = restart || state_q == IDLE;
  // A new request always beats the natural end of the sequence.
  always_comb begin
    state_d = trig ? PLAY : last_end ? IDLE : state_q;
    sel_d = trig ? sound_t'(soundselector) : sel_q;
    step_d = trig ? 2'd0 : (step_end && !last_end) ? step_q + 2'd1 : step_q;
    pre_d = (clear || tick_end) ? '0 : pre_q + 1'b1;
    dur_d = clear ? '0 : dur_q + 8'(tick_end);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= UI_PRESS;
      step_q <= '0;
      pre_q <= '0;
      dur_q <= '0;
      play_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      step_q <= step_d;
      pre_q <= pre_d;
      dur_q <= dur_d;
      play_q <= playsound;
    end
  end
  tone_gen #(.W(HPW)) u_tone (
    .clk(clk),
    .reset(reset),
    .restart(restart),
    .half_period(hp_tab[sel_q][step_q]),
    .sq(sq)
  );
  assign busy = state_q == PLAY;
  assign done = last_end & ~trig;
  assign audio_out = sq & busy & ~mute & ~last_end;
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed sequences with hand-computed busy/done/toggle expectations.
module tb_sound_player;
  logic clk = 1'b0, reset = 1'b1, playsound = 1'b0, mute = 1'b0;
  logic [1:0] soundselector = 2'd0;
  logic audio_out, busy, done;
  int total = 0, bad = 0;
  int busy_n, busy_first, busy_last, done_n, done_at;
  int r, h, f;
  logic aud [0:32767];

  sound_player #(.CLK_HZ(100_000), .TICK_HZ(1000)) dut (
    .clk(clk),
    .reset(reset),
    .soundselector(soundselector),
    .playsound(playsound),
    .mute(mute),
    .audio_out(audio_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycle 0 raises playsound; the edge closing cycle c is the trigger edge for cycle c+1.
  task automatic play(input logic [1:0] s1, input int n, input int hold, input int p2,
                      input logic [1:0] s2, input int rst_at);
    busy_n = 0; busy_first = -1; busy_last = -1; done_n = 0; done_at = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      soundselector = (c == p2) ? s2 : s1;
      playsound = c < hold || c == p2;
      reset = c == rst_at;
      @(negedge clk);
      aud[c] = audio_out;
      if (busy) begin
        busy_n++;
        busy_last = c;
        if (busy_first < 0) busy_first = c;
      end
      if (done) begin
        done_n++;
        done_at = c;
      end
    end
    @(posedge clk); #1;
    playsound = 1'b0;
    reset = 1'b0;
  endtask

  task automatic seg(input int lo, input int hi, output int rises, output int highs, output int first);
    rises = 0; highs = 0; first = -1;
    for (int c = lo; c <= hi; c++) begin
      highs += int'(aud[c]);
      if (c > 0 && aud[c] && !aud[c-1]) begin
        rises++;
        if (first < 0) first = c;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst audio", int'(audio_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    play(2'd0, 3100, 1, -1, 2'd0, -1);
    chk("ui busy_n", busy_n, 3000);
    chk("ui busy_first", busy_first, 1);
    chk("ui busy_last", busy_last, 3000);
    chk("ui done_n", done_n, 1);
    chk("ui done_at", done_at, 3000);
    seg(1, 3000, r, h, f);
    chk("ui rises", r, 30);
    chk("ui highs", h, 1499);
    chk("ui first_rise", f, 51);
    chk("ui end_low", int'(aud[3000]), 0);

    play(2'd1, 12100, 1, -1, 2'd0, -1);
    chk("nl busy_n", busy_n, 12000);
    chk("nl done_n", done_n, 1);
    chk("nl done_at", done_at, 12000);
    seg(1, 6000, r, h, f);
    chk("nl s0 rises", r, 30);
    chk("nl s0 highs", h, 3000);
    chk("nl s0 first", f, 101);
    seg(6001, 12000, r, h, f);
    chk("nl s1 rises", r, 60);
    chk("nl s1 highs", h, 2999);
    chk("nl s1 first", f, 6051);

    play(2'd2, 30100, 1, -1, 2'd0, -1);
    chk("cr busy_n", busy_n, 30000);
    chk("cr done_n", done_n, 1);
    chk("cr done_at", done_at, 30000);
    seg(1, 10000, r, h, f);
    chk("cr s0 rises", r, 25);
    chk("cr s0 highs", h, 5000);
    chk("cr s0 first", f, 201);
    seg(10001, 15000, r, h, f);
    chk("cr rest highs", h, 0);
    seg(15001, 30000, r, h, f);
    chk("cr s2 rises", r, 19);
    chk("cr s2 highs", h, 7399);
    chk("cr s2 first", f, 15401);

    play(2'd3, 8200, 1, 5000, 2'd0, -1);
    seg(1, 4000, r, h, f);
    chk("ce s0 rises", r, 20);
    seg(4001, 5000, r, h, f);
    chk("ce s1 rises", r, 6);
    chk("ce s1 first", f, 4081);
    seg(5001, 8000, r, h, f);
    chk("pre rises", r, 30);
    chk("pre first", f, 5051);
    chk("pre highs", h, 1499);
    chk("pre busy_n", busy_n, 8000);
    chk("pre done_n", done_n, 1);
    chk("pre done_at", done_at, 8000);

    play(2'd0, 6100, 1, 3000, 2'd0, -1);
    chk("coin busy_n", busy_n, 6000);
    chk("coin done_n", done_n, 1);
    chk("coin done_at", done_at, 6000);

    play(2'd0, 20000, 20000, -1, 2'd0, -1);
    chk("hold busy_n", busy_n, 3000);
    chk("hold done_n", done_n, 1);
    chk("hold done_at", done_at, 3000);

    mute = 1'b1;
    play(2'd2, 2500, 1, -1, 2'd0, 2000);
    mute = 1'b0;
    seg(0, 2499, r, h, f);
    chk("mrst highs", h, 0);
    chk("mrst busy_n", busy_n, 2000);
    chk("mrst busy_last", busy_last, 2000);
    chk("mrst done_n", done_n, 0);

    play(2'd0, 3100, 3100, -1, 2'd0, 0);
    chk("rel busy_first", busy_first, 2);
    chk("rel done_at", done_at, 3001);
    chk("rel done_n", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
